// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_buf
// Brief    : Two-entry valid/ready skid buffer with fully registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            count
);

  // State encoding equals the stored-word count, so count comes straight off the state flops.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  r_s_ready;
  logic                  r_m_valid;
  logic                  w_s_ready_nxt;
  logic                  w_m_valid_nxt;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_load_main_in;
  logic                  w_load_main_skid;
  logic                  w_load_skid;

  assign w_in_xfer  = s_valid & r_s_ready;
  assign w_out_xfer = r_m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_FULL;
          end else if (w_out_xfer) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = S_ONE;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs are precomputed from the next state and registered.
  always_comb begin
    w_s_ready_nxt = (w_state_nxt != S_FULL);
    w_m_valid_nxt = (w_state_nxt != S_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
    end else begin
      r_s_ready <= w_s_ready_nxt;
      r_m_valid <= w_m_valid_nxt;
    end
  end

  // Flush clears the skid word but leaves the main word visible on m_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= s_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (flush) begin
        r_skid <= '0;
      end else if (w_load_skid) begin
        r_skid <= s_data;
      end
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_main;
  assign count   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_buf
// Brief    : Directed and random scoreboard bench for pipe_skid_buf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_buf;

  localparam int DATA_WIDTH = 32;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic [1:0]            count;

  int checks   = 0;
  int failures = 0;

  logic [DATA_WIDTH-1:0] sb_q[$];
  int                    mdl_cnt  = 0;
  bit                    mdl_init = 1'b0;

  pipe_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_WIDTH-1:0] act,
                       input logic [DATA_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy model plus in-order scoreboard of accepted words.
  always @(posedge clk) begin
    bit in_x;
    bit out_x;
    if (!rst_n) begin
      sb_q.delete();
      mdl_cnt  = 0;
      mdl_init = 1'b1;
    end else if (mdl_init) begin
      check("mon_s_ready", {31'd0, s_ready}, {31'd0, (mdl_cnt < 2)});
      check("mon_m_valid", {31'd0, m_valid}, {31'd0, (mdl_cnt > 0)});
      check("mon_count",   {30'd0, count},   mdl_cnt);
      in_x  = s_valid && (mdl_cnt < 2);
      out_x = m_ready && (mdl_cnt > 0);
      if (flush) begin
        sb_q.delete();
        mdl_cnt = 0;
      end else begin
        if (out_x) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon_unexpected_word: got 0x%0h expected no word", m_data);
          end else begin
            check("mon_m_data", m_data, sb_q.pop_front());
          end
          mdl_cnt--;
        end
        if (in_x) begin
          sb_q.push_back(s_data);
          mdl_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    m_ready = 1'b1;

    // Reset with a word offered: nothing may be captured.
    step();
    step();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data",  m_data,           32'd0);
    check("rst_count",   {30'd0, count},   32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    step();
    step();
    check("rst_no_word", {31'd0, m_valid}, 32'd0);

    // Streaming 1,2,3 with downstream always ready.
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h1;
    step();
    check("stream_first", m_data, 32'h1);
    check("stream_cnt1",  {30'd0, count}, 32'd1);
    s_data = 32'h2;
    step();
    check("stream_second", m_data, 32'h2);
    s_data = 32'h3;
    step();
    check("stream_third", m_data, 32'h3);
    check("stream_ready", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b0;
    step();
    check("stream_empty", {31'd0, m_valid}, 32'd0);
    check("stream_hold",  m_data, 32'h3);

    // Stall fill: A then B, then C offered while full.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hA;
    step();
    s_data = 32'hB;
    step();
    check("stall_count",   {30'd0, count},   32'd2);
    check("stall_s_ready", {31'd0, s_ready}, 32'd0);
    check("stall_m_data",  m_data,           32'hA);
    s_data = 32'hC;
    step();
    check("stall_c_refused", {30'd0, count}, 32'd2);
    check("stall_held",      m_data,         32'hA);

    // Drain: A leaves, B moves up, C accepted when ready returns.
    m_ready = 1'b1;
    step();
    check("drain_b",       m_data,           32'hB);
    check("drain_s_ready", {31'd0, s_ready}, 32'd1);
    step();
    check("drain_c", m_data, 32'hC);
    s_valid = 1'b0;
    step();
    check("drain_empty", {30'd0, count}, 32'd0);

    // Flush while full, with a word offered in the flush cycle.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h10;
    step();
    s_data = 32'h11;
    step();
    check("flush_pre_count", {30'd0, count}, 32'd2);
    flush  = 1'b1;
    s_data = 32'h12;
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    check("flush_count",   {30'd0, count},   32'd0);
    check("flush_m_valid", {31'd0, m_valid}, 32'd0);
    check("flush_s_ready", {31'd0, s_ready}, 32'd1);
    check("flush_m_data",  m_data,           32'h10);
    m_ready = 1'b1;
    repeat (3) step();
    check("flush_no_word", {31'd0, m_valid}, 32'd0);

    // Random traffic; the monitor checks order, loss, duplication and stability.
    for (int i = 0; i < 10000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (4) step();
    check("final_queue_empty", sb_q.size(), 32'd0);
    check("final_count",       {30'd0, count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
